// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, per-character error flags and a
// first-word-fall-through receive FIFO with overrun and character-timeout status.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH    = 16,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        RX_I,
  input  logic [15:0] DIVISOR_I,
  input  logic [1:0]  WLS_I,
  input  logic        PEN_I,
  input  logic        EPS_I,
  input  logic        FIFO_CLR_I,
  input  logic        RD_I,
  input  logic        CLR_OE_I,
  output logic [7:0]  DAT_O,
  output logic        PE_O,
  output logic        FE_O,
  output logic        BI_O,
  output logic        DR_O,
  output logic        OE_O,
  output logic [8:0]  COUNT_O,
  output logic        TIMEOUT_O
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] TO_CHARS = 32'(TIMEOUT_CHARS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT} state_t;

  logic          r_rx_s1, r_rx_s2, r_rx_d;
  logic          w_rx, w_fall;
  logic [15:0]   r_div_cnt, r_div_m1, w_div_m1;
  logic          w_tick;
  state_t        r_state;
  logic [3:0]    r_sub;
  logic [2:0]    r_bitcnt, w_last;
  logic [7:0]    r_shift;
  logic          r_par, r_pe, r_allz;
  logic [1:0]    r_wls;
  logic          r_pen, r_eps;
  logic          r_push;
  logic [10:0]   r_push_dat;
  logic [10:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [8:0]    r_count;
  logic          r_oe;
  logic          w_full, w_pop, w_wr, w_ovr;
  logic [10:0]   w_head;
  logic [3:0]    w_frame_bits;
  logic [31:0]   w_to_thr, r_to_cnt;
  logic          r_timeout;

  // Input synchronizer; r_rx_d holds the previous synchronized level for edge detection
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= RX_I;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  assign w_rx   = r_rx_s2;
  assign w_fall = r_rx_d & ~w_rx;

  // Oversample tick; the divisor is re-latched only at the wrap
  assign w_div_m1 = (DIVISOR_I == 16'd0) ? 16'd0 : DIVISOR_I - 16'd1;
  assign w_tick   = (r_div_cnt == r_div_m1);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_div_cnt <= 16'd0;
      r_div_m1  <= 16'd0;
    end else if (w_tick) begin
      r_div_cnt <= 16'd0;
      r_div_m1  <= w_div_m1;
    end else begin
      r_div_cnt <= r_div_cnt + 16'd1;
    end
  end

  assign w_last = 3'd4 + {1'b0, r_wls};

  // Receive FSM: every bit is sampled at sub-tick 7, the middle of the bit cell
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state    <= S_IDLE;
      r_sub      <= 4'd0;
      r_bitcnt   <= 3'd0;
      r_shift    <= 8'd0;
      r_par      <= 1'b0;
      r_pe       <= 1'b0;
      r_allz     <= 1'b0;
      r_wls      <= 2'd0;
      r_pen      <= 1'b0;
      r_eps      <= 1'b0;
      r_push     <= 1'b0;
      r_push_dat <= 11'd0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state  <= S_START;
            r_sub    <= 4'd0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_par    <= 1'b0;
            r_pe     <= 1'b0;
            r_allz   <= 1'b1;
            r_wls    <= WLS_I;
            r_pen    <= PEN_I;
            r_eps    <= EPS_I;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_sub <= r_sub + 4'd1;
            if (r_sub == 4'd7) r_state <= w_rx ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_sub <= r_sub + 4'd1;
            if (r_sub == 4'd7) begin
              r_shift[r_bitcnt] <= w_rx;
              r_par             <= r_par ^ w_rx;
              if (w_rx) r_allz <= 1'b0;
              if (r_bitcnt == w_last) r_state <= r_pen ? S_PARITY : S_STOP;
              else r_bitcnt <= r_bitcnt + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_sub <= r_sub + 4'd1;
            if (r_sub == 4'd7) begin
              r_pe <= ((r_par ^ w_rx) == r_eps);
              if (w_rx) r_allz <= 1'b0;
              r_state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_sub <= r_sub + 4'd1;
            if (r_sub == 4'd7) begin
              r_push     <= 1'b1;
              r_push_dat <= {r_allz & ~w_rx, ~w_rx, r_pe, r_shift};
              r_state    <= w_rx ? S_IDLE : S_BRKWAIT;
            end
          end
        end
        S_BRKWAIT: begin
          if (w_rx) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO: a pop frees the head slot, so push+pop is accepted even when full
  assign w_full = (r_count == 9'(FIFO_DEPTH));
  assign w_pop  = RD_I && (r_count != 9'd0) && !FIFO_CLR_I;
  assign w_wr   = r_push && (!w_full || w_pop) && !FIFO_CLR_I;
  assign w_ovr  = r_push && w_full && !w_pop && !FIFO_CLR_I;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 9'd0;
      r_oe     <= 1'b0;
    end else begin
      if (FIFO_CLR_I) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= 9'd0;
      end else begin
        if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_wr && !w_pop)      r_count <= r_count + 9'd1;
        else if (w_pop && !w_wr) r_count <= r_count - 9'd1;
      end
      if (w_ovr)         r_oe <= 1'b1;
      else if (CLR_OE_I) r_oe <= 1'b0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_dat;
  end

  // Character timeout, scaled by the frame format of the last received character
  assign w_frame_bits = 4'd7 + {2'b00, r_wls} + {3'b000, r_pen};
  assign w_to_thr     = TO_CHARS * {28'd0, w_frame_bits} * 32'd16;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_to_cnt  <= 32'd0;
      r_timeout <= 1'b0;
    end else if (r_push || w_pop || FIFO_CLR_I) begin
      r_to_cnt  <= 32'd0;
      r_timeout <= 1'b0;
    end else if ((r_count != 9'd0) && w_tick && !r_timeout) begin
      r_to_cnt <= r_to_cnt + 32'd1;
      if (r_to_cnt + 32'd1 >= w_to_thr) r_timeout <= 1'b1;
    end
  end

  assign w_head    = (r_count != 9'd0) ? r_mem[r_rd_ptr] : 11'd0;
  assign DAT_O     = w_head[7:0];
  assign PE_O      = w_head[8];
  assign FE_O      = w_head[9];
  assign BI_O      = w_head[10];
  assign DR_O      = (r_count != 9'd0);
  assign OE_O      = r_oe;
  assign COUNT_O   = r_count;
  assign TIMEOUT_O = r_timeout;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus randomized frames checked
// against a queue-based model of received characters.
module tb_uart_rx_fifo;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic        RX_I = 1'b1;
  logic [15:0] DIVISOR_I = 16'd1;
  logic [1:0]  WLS_I = 2'b11;
  logic        PEN_I = 1'b0;
  logic        EPS_I = 1'b0;
  logic        FIFO_CLR_I = 1'b0;
  logic        RD_I = 1'b0;
  logic        CLR_OE_I = 1'b0;
  logic [7:0]  DAT_O;
  logic        PE_O, FE_O, BI_O, DR_O, OE_O, TIMEOUT_O;
  logic [8:0]  COUNT_O;

  int n_vec = 0;
  int n_err = 0;
  logic [10:0] q_model[$];

  uart_rx_fifo #(.FIFO_DEPTH(16), .TIMEOUT_CHARS(4)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .RX_I(RX_I), .DIVISOR_I(DIVISOR_I),
    .WLS_I(WLS_I), .PEN_I(PEN_I), .EPS_I(EPS_I), .FIFO_CLR_I(FIFO_CLR_I),
    .RD_I(RD_I), .CLR_OE_I(CLR_OE_I), .DAT_O(DAT_O), .PE_O(PE_O),
    .FE_O(FE_O), .BI_O(BI_O), .DR_O(DR_O), .OE_O(OE_O), .COUNT_O(COUNT_O),
    .TIMEOUT_O(TIMEOUT_O)
  );

  always #5 CLK_I = ~CLK_I;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold(input int n);
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  // Parity bit a transmitter would send, optionally inverted to inject an error
  function automatic logic par_bit(input logic [7:0] d, input int nb, input logic eps, input logic bad);
    int ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    return ((eps ? (ones % 2 == 1) : (ones % 2 == 0)) ? 1'b1 : 1'b0) ^ bad;
  endfunction

  // Expected FIFO entry {BI,FE,PE,data} for a frame as it appeared on the line
  function automatic logic [10:0] model_entry(input logic [7:0] d, input int nb, input logic pen,
                                              input logic pbit, input logic eps, input logic stop);
    int ones = 0;
    logic [7:0] dm;
    logic pe, fe, bi;
    dm = d & 8'((1 << nb) - 1);
    for (int i = 0; i < nb; i++) ones += int'(dm[i]);
    if (pen) ones += int'(pbit);
    pe = pen && (eps ? (ones % 2 != 0) : (ones % 2 != 1));
    fe = !stop;
    bi = (dm == 8'd0) && (!pen || !pbit) && !stop;
    return {bi, fe, pe, dm};
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic [1:0] wls, input logic pen,
                            input logic eps, input logic bad, input logic stop, input int idle_bits);
    int bt, nb;
    bt = 16 * ((DIVISOR_I == 16'd0) ? 1 : int'(DIVISOR_I));
    nb = 5 + int'(wls);
    WLS_I = wls; PEN_I = pen; EPS_I = eps;
    RX_I = 1'b0; hold(bt);
    for (int i = 0; i < nb; i++) begin RX_I = d[i]; hold(bt); end
    if (pen) begin RX_I = par_bit(d, nb, eps, bad); hold(bt); end
    RX_I = stop; hold(bt);
    RX_I = 1'b1; hold(bt * idle_bits);
  endtask

  task automatic pop_one;
    RD_I = 1'b1; hold(1); RD_I = 1'b0;
  endtask

  task automatic test_reset;
    RST_I = 1'b0; hold(3);
    n_vec++;
    if ({DAT_O, PE_O, FE_O, BI_O, DR_O, OE_O, COUNT_O, TIMEOUT_O} !== 23'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got dat=%h pe=%b fe=%b bi=%b dr=%b oe=%b cnt=%0d to=%b expected all 0",
               DAT_O, PE_O, FE_O, BI_O, DR_O, OE_O, COUNT_O, TIMEOUT_O);
    end
    RST_I = 1'b1; hold(4);
  endtask

  task automatic test_basic;
    int lat = 0;
    DIVISOR_I = 16'd1; hold(4);
    fork
      send_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2);
      begin
        while (DR_O !== 1'b1 && lat < 400) begin @(posedge CLK_I); #1; lat++; end
      end
    join
    n_vec++;
    if (lat < 150 || lat > 160) begin
      n_err++; $display("FAIL push_latency: got %0d cycles expected 150..160", lat);
    end
    n_vec++;
    if ({DAT_O, DR_O, COUNT_O, PE_O, FE_O, BI_O} !== {8'h55, 1'b1, 9'd1, 3'b000}) begin
      n_err++; $display("FAIL basic_8n1: got dat=%h dr=%b cnt=%0d pfb=%b%b%b expected 55 1 1 000",
                        DAT_O, DR_O, COUNT_O, PE_O, FE_O, BI_O);
    end
    pop_one;
    n_vec++;
    if ({DR_O, COUNT_O} !== {1'b0, 9'd0}) begin
      n_err++; $display("FAIL basic_pop: got dr=%b cnt=%0d expected 0 0", DR_O, COUNT_O);
    end
  endtask

  task automatic test_parity;
    send_frame(8'hA7, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2);
    n_vec++;
    if ({DAT_O, PE_O, FE_O, BI_O} !== {8'hA7, 3'b100}) begin
      n_err++; $display("FAIL parity_err: got dat=%h pfb=%b%b%b expected a7 100", DAT_O, PE_O, FE_O, BI_O);
    end
    pop_one;
    n_vec++;
    if ({DR_O, DAT_O} !== 9'd0) begin
      n_err++; $display("FAIL parity_pop: got dr=%b dat=%h expected 0 00", DR_O, DAT_O);
    end
  endtask

  task automatic test_overrun;
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    n_vec++;
    if ({COUNT_O, OE_O, DAT_O} !== {9'd16, 1'b1, 8'h00}) begin
      n_err++; $display("FAIL overrun: got cnt=%0d oe=%b dat=%h expected 16 1 00", COUNT_O, OE_O, DAT_O);
    end
    CLR_OE_I = 1'b1; hold(1); CLR_OE_I = 1'b0;
    n_vec++;
    if (OE_O !== 1'b0) begin
      n_err++; $display("FAIL clr_oe: got oe=%b expected 0", OE_O);
    end
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (DAT_O !== 8'(i)) begin
        n_err++; $display("FAIL overrun_order[%0d]: got %h expected %h", i, DAT_O, 8'(i));
      end
      pop_one;
    end
    n_vec++;
    if ({COUNT_O, DR_O} !== 10'd0) begin
      n_err++; $display("FAIL overrun_drain: got cnt=%0d dr=%b expected 0 0", COUNT_O, DR_O);
    end
  endtask

  task automatic test_fifo_clr;
    send_frame(8'h11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    send_frame(8'h22, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    FIFO_CLR_I = 1'b1; hold(1); FIFO_CLR_I = 1'b0;
    n_vec++;
    if ({COUNT_O, DR_O, DAT_O} !== 18'd0) begin
      n_err++; $display("FAIL fifo_clr: got cnt=%0d dr=%b dat=%h expected 0 0 00", COUNT_O, DR_O, DAT_O);
    end
  endtask

  task automatic test_break;
    WLS_I = 2'b11; PEN_I = 1'b0;
    RX_I = 1'b0; hold(4); RX_I = 1'b1; hold(300);
    n_vec++;
    if (COUNT_O !== 9'd0) begin
      n_err++; $display("FAIL false_start: got cnt=%0d expected 0", COUNT_O);
    end
    RX_I = 1'b0; hold(12 * 16);
    n_vec++;
    if ({COUNT_O, BI_O, FE_O, PE_O, DAT_O} !== {9'd1, 3'b110, 8'h00}) begin
      n_err++; $display("FAIL break_entry: got cnt=%0d bfp=%b%b%b dat=%h expected 1 110 00",
                        COUNT_O, BI_O, FE_O, PE_O, DAT_O);
    end
    hold(200); RX_I = 1'b1; hold(64);
    n_vec++;
    if (COUNT_O !== 9'd1) begin
      n_err++; $display("FAIL break_single: got cnt=%0d expected 1", COUNT_O);
    end
    pop_one;
  endtask

  task automatic test_timeout;
    int t1 = 0;
    int t2 = 0;
    DIVISOR_I = 16'd2; hold(8);
    fork
      send_frame(8'h9A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1);
      begin
        while (DR_O !== 1'b1 && t1 < 1000) begin @(posedge CLK_I); #1; t1++; end
        while (TIMEOUT_O !== 1'b1 && t2 < 3000) begin @(posedge CLK_I); #1; t2++; end
      end
    join
    n_vec++;
    if (t1 >= 1000 || t2 < 1276 || t2 > 1284) begin
      n_err++; $display("FAIL timeout_delay: got %0d cycles after push expected 1276..1284", t2);
    end
    hold(50);
    n_vec++;
    if (TIMEOUT_O !== 1'b1) begin
      n_err++; $display("FAIL timeout_sticky: got %b expected 1", TIMEOUT_O);
    end
    pop_one;
    n_vec++;
    if ({TIMEOUT_O, DR_O} !== 2'b00) begin
      n_err++; $display("FAIL timeout_clear: got to=%b dr=%b expected 0 0", TIMEOUT_O, DR_O);
    end
  endtask

  task automatic test_reset_midframe;
    DIVISOR_I = 16'd1; hold(4);
    send_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    RX_I = 1'b0; hold(16);
    for (int i = 0; i < 3; i++) begin RX_I = 1'b1; hold(16); end
    RX_I = 1'b1; hold(8);
    RST_I = 1'b0; hold(2);
    n_vec++;
    if ({COUNT_O, DR_O} !== 10'd0) begin
      n_err++; $display("FAIL midframe_reset: got cnt=%0d dr=%b expected 0 0", COUNT_O, DR_O);
    end
    hold(6 + 5 * 16 + 32);
    RST_I = 1'b1; hold(32);
    n_vec++;
    if (COUNT_O !== 9'd0) begin
      n_err++; $display("FAIL midframe_nopush: got cnt=%0d expected 0", COUNT_O);
    end
    send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    n_vec++;
    if ({COUNT_O, DAT_O, PE_O, FE_O, BI_O} !== {9'd1, 8'h3C, 3'b000}) begin
      n_err++; $display("FAIL after_reset_rx: got cnt=%0d dat=%h pfb=%b%b%b expected 1 3c 000",
                        COUNT_O, DAT_O, PE_O, FE_O, BI_O);
    end
    pop_one;
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic [1:0] wls;
    logic pen, eps, bad, stop, pbit;
    logic [10:0] exp_e;
    q_model.delete();
    for (int f = 0; f < 40; f++) begin
      if (f % 10 == 0) begin DIVISOR_I = 16'($urandom_range(0, 2)); hold(8); end
      d    = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'd0;
      wls  = 2'($urandom);
      pen  = 1'($urandom);
      eps  = 1'($urandom);
      bad  = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 7) != 0);
      pbit = par_bit(d, 5 + int'(wls), eps, bad);
      send_frame(d, wls, pen, eps, bad, stop, 1);
      q_model.push_back(model_entry(d, 5 + int'(wls), pen, pbit, eps, stop));
      n_vec++;
      if (COUNT_O !== 9'(q_model.size())) begin
        n_err++; $display("FAIL rand_count[%0d]: got %0d expected %0d", f, COUNT_O, q_model.size());
      end
      while (q_model.size() > 0 && (q_model.size() >= 15 || $urandom_range(0, 1) == 1)) begin
        exp_e = q_model.pop_front();
        n_vec++;
        if ({BI_O, FE_O, PE_O, DAT_O} !== exp_e) begin
          n_err++; $display("FAIL rand_entry[%0d]: got %h expected %h", f, {BI_O, FE_O, PE_O, DAT_O}, exp_e);
        end
        pop_one;
      end
    end
    while (q_model.size() > 0) begin
      exp_e = q_model.pop_front();
      n_vec++;
      if ({BI_O, FE_O, PE_O, DAT_O} !== exp_e) begin
        n_err++; $display("FAIL rand_drain: got %h expected %h", {BI_O, FE_O, PE_O, DAT_O}, exp_e);
      end
      pop_one;
    end
    n_vec++;
    if ({COUNT_O, DR_O} !== 10'd0) begin
      n_err++; $display("FAIL rand_empty: got cnt=%0d dr=%b expected 0 0", COUNT_O, DR_O);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_overrun;
    test_fifo_clr;
    test_break;
    test_timeout;
    test_reset_midframe;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
